// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 keyboard receiver.
//   - frame FSM state encoding (2 bits)
//   - frame length and default parameter values
//   - odd-parity helper used when PS2_PARITY_CHECK_EN is defined
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  localparam int FRAME_BITS         = 11;
  localparam int TIMEOUT_DEFAULT    = 2500;
  localparam int DEPTH_LOG2_DEFAULT = 3;

  // PS/2 uses odd parity: data bits plus parity bit must XOR to 1.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// ps2_fifo: synchronous scancode FIFO, 2^DEPTH_LOG2 entries of 8 bits.
// Ports:
//   clock, reset    system clock, synchronous active-high reset
//   push, wdata     write request and scancode
//   pop             read strobe (ignored while empty)
//   head            combinational read of the oldest entry
//   full, empty     occupancy flags
//   ovf             one-cycle pulse: push rejected because FIFO was full
// A push and a pop in the same cycle both take effect, even when full.
module ps2_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] head,
  output logic       full,
  output logic       empty,
  output logic       ovf
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = count[DEPTH_LOG2];
  assign do_pop  = pop & ~empty;
  // A simultaneous pop frees the slot, so a push while full still lands.
  assign do_push = push & (~full | do_pop);
  assign ovf     = push & full & ~do_pop;
  assign head    = mem[rptr];

  // Storage, pointers and occupancy count.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + DEPTH_LOG2'(1);
      end
      if (do_pop) begin
        rptr <= rptr + DEPTH_LOG2'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (DEPTH_LOG2 + 1)'(1);
        2'b01:   count <= count - (DEPTH_LOG2 + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_keyboard.sv
// ps2_keyboard: receive-only PS/2 keyboard interface with scancode FIFO.
// Ports:
//   clock, reset   25 MHz system clock, synchronous active-high reset
//   ps2_clk        raw PS/2 clock line (asynchronous)
//   ps2_dat        raw PS/2 data line (asynchronous)
//   rd             one-cycle pop strobe
//   clr            one-cycle clear of overflow / frame_err
//   data           FIFO head scancode, valid while ready=1
//   ready          FIFO non-empty
//   overflow       sticky: frame arrived while FIFO full
//   frame_err      sticky: bad start, stop (or parity) bit
// Build option: define PS2_PARITY_CHECK_EN to reject frames with bad odd parity;
// otherwise the parity bit is captured but ignored.
module ps2_keyboard
  import ps2_pkg::*;
#(
  parameter int TIMEOUT    = TIMEOUT_DEFAULT,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic       rd,
  input  logic       clr,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic          clk_s1, clk_s2, clk_prev;
  logic          dat_s1, dat_s2;
  logic          fall;
  ps2_state_t    state, state_nx;
  logic [2:0]    bitcnt, bitcnt_nx;
  logic [7:0]    shreg, shreg_nx;
  logic          par, par_nx;
  logic [TW-1:0] timer, timer_nx;
  logic          push, err_evt, frame_good;
  logic          fifo_empty, ovf_evt;
  logic          unused_fifo_full;

  // Two-flop synchronisers plus previous-clock flop for edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_s1   <= 1'b0;
      clk_s2   <= 1'b0;
      clk_prev <= 1'b0;
      dat_s1   <= 1'b0;
      dat_s2   <= 1'b0;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_dat;
      dat_s2   <= dat_s1;
    end
  end

  // Flops all reset low, so no spurious falling edge right after reset.
  assign fall = clk_prev & ~clk_s2;

`ifdef PS2_PARITY_CHECK_EN
  assign frame_good = dat_s2 & odd_parity_ok(shreg, par);
`else
  logic unused_par;
  assign unused_par = par;
  assign frame_good = dat_s2;
`endif

  // Frame FSM next-state, shift register, parity capture and idle timeout.
  always_comb begin
    state_nx  = state;
    bitcnt_nx = bitcnt;
    shreg_nx  = shreg;
    par_nx    = par;
    timer_nx  = timer;
    push      = 1'b0;
    err_evt   = 1'b0;
    if (fall) begin
      timer_nx = '0;
      case (state)
        ST_IDLE: begin
          if (!dat_s2) begin
            bitcnt_nx = 3'd0;
            state_nx  = ST_DATA;
          end else begin
            err_evt = 1'b1;
          end
        end
        ST_DATA: begin
          // LSB first: each new bit enters at the top and moves down.
          shreg_nx  = {dat_s2, shreg[7:1]};
          bitcnt_nx = bitcnt + 3'd1;
          if (bitcnt == 3'd7) begin
            state_nx = ST_PARITY;
          end else begin
            state_nx = ST_DATA;
          end
        end
        ST_PARITY: begin
          par_nx   = dat_s2;
          state_nx = ST_STOP;
        end
        ST_STOP: begin
          if (frame_good) begin
            push = 1'b1;
          end else begin
            err_evt = 1'b1;
          end
          state_nx = ST_IDLE;
        end
        default: state_nx = ST_IDLE;
      endcase
    end else if (state != ST_IDLE) begin
      // A stalled partial frame is silently abandoned.
      if (timer == TW'(TIMEOUT)) begin
        state_nx = ST_IDLE;
        timer_nx = '0;
      end else begin
        timer_nx = timer + TW'(1);
      end
    end else begin
      timer_nx = '0;
    end
  end

  // FSM state, datapath registers and sticky flags (set beats clear).
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      bitcnt    <= 3'd0;
      shreg     <= 8'h00;
      par       <= 1'b0;
      timer     <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state  <= state_nx;
      bitcnt <= bitcnt_nx;
      shreg  <= shreg_nx;
      par    <= par_nx;
      timer  <= timer_nx;
      if (ovf_evt) begin
        overflow <= 1'b1;
      end else if (clr) begin
        overflow <= 1'b0;
      end
      if (err_evt) begin
        frame_err <= 1'b1;
      end else if (clr) begin
        frame_err <= 1'b0;
      end
    end
  end

  ps2_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (rd),
    .wdata (shreg),
    .head  (data),
    .full  (unused_fifo_full),
    .empty (fifo_empty),
    .ovf   (ovf_evt)
  );

  assign ready = ~fifo_empty;

endmodule

// File: tb/tb_ps2_keyboard.sv
// tb_ps2_keyboard: directed, table-driven bench for ps2_keyboard.
// Inputs change on the falling edge of clock; outputs are sampled there too.
module tb_ps2_keyboard;

  logic       clock;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_dat;
  logic       rd;
  logic       clr;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  int checks;
  int errors;
  logic rdy_e2;
  logic rdy_e3;

  typedef struct {
    logic [7:0] b;
    logic       bad_par;
    logic       bad_stop;
    logic       exp_ready;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t vt[6];

  ps2_keyboard dut (
    .clock     (clock),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .rd        (rd),
    .clr       (clr),
    .data      (data),
    .ready     (ready),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  initial clock = 1'b0;
  always #20 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One PS/2 bit: data set, clock high for 'half' cycles, then falls.
  // Optional rd/clr strobe lands in the cycle the DUT acts on this fall.
  task automatic ps2_edge(input logic b, input int half, input logic s_rd, input logic s_clr);
    ps2_dat = b;
    repeat (half) @(negedge clock);
    ps2_clk = 1'b0;
    @(negedge clock);
    @(negedge clock);
    rdy_e2 = ready;
    rd  = s_rd;
    clr = s_clr;
    @(negedge clock);
    rdy_e3 = ready;
    rd  = 1'b0;
    clr = 1'b0;
    repeat (half - 3) @(negedge clock);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                            input int half, input logic s_rd);
    logic p;
    p = ~(^b) ^ bad_par;
    ps2_edge(1'b0, half, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      ps2_edge(b[i], half, 1'b0, 1'b0);
    end
    ps2_edge(p, half, 1'b0, 1'b0);
    ps2_edge(~bad_stop, half, s_rd, 1'b0);
    repeat (4) @(negedge clock);
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    @(negedge clock);
    rd = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clock);
    clr = 1'b0;
  endtask

  task automatic pop_chk(input string name, input logic [7:0] exp);
    chk({name, "_ready"}, {31'd0, ready}, 32'd1);
    chk({name, "_data"}, {24'd0, data}, {24'd0, exp});
    pulse_rd();
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_dat  = 1'b1;
    rd       = 1'b0;
    clr      = 1'b0;

    vt[0] = '{8'h1C, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b0};
    vt[1] = '{8'hF0, 1'b0, 1'b0, 1'b1, 8'hF0, 1'b0};
    vt[2] = '{8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0};
    vt[3] = '{8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0};
    vt[4] = '{8'h1C, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
`ifdef PS2_PARITY_CHECK_EN
    vt[5] = '{8'h1C, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
`else
    vt[5] = '{8'h1C, 1'b1, 1'b0, 1'b1, 8'h1C, 1'b0};
`endif

    repeat (3) @(negedge clock);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_data", {24'd0, data}, 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    // 0x1C at 12.5 kHz PS/2 clock, latency from the stop-bit fall.
    send_frame(8'h1C, 1'b0, 1'b0, 1000, 1'b0);
    chk("lat_ready_e2", {31'd0, rdy_e2}, 32'd0);
    chk("lat_ready_e3", {31'd0, rdy_e3}, 32'd1);
    pop_chk("lat", 8'h1C);
    chk("lat_empty", {31'd0, ready}, 32'd0);

    // Table-driven frames.
    for (int i = 0; i < 6; i++) begin
      send_frame(vt[i].b, vt[i].bad_par, vt[i].bad_stop, 20, 1'b0);
      chk($sformatf("vec%0d_ready", i), {31'd0, ready}, {31'd0, vt[i].exp_ready});
      if (vt[i].exp_ready) begin
        chk($sformatf("vec%0d_data", i), {24'd0, data}, {24'd0, vt[i].exp_data});
      end
      chk($sformatf("vec%0d_err", i), {31'd0, frame_err}, {31'd0, vt[i].exp_err});
      if (ready) pulse_rd();
      pulse_clr();
      chk($sformatf("vec%0d_clr", i), {30'd0, ready, frame_err}, 32'd0);
    end

    // Bad start bit with clr in the same cycle: set wins.
    ps2_edge(1'b1, 20, 1'b0, 1'b1);
    repeat (2) @(negedge clock);
    chk("clr_vs_set", {31'd0, frame_err}, 32'd1);
    pulse_clr();
    chk("clr_after", {31'd0, frame_err}, 32'd0);

    // Partial frame abandoned by timeout, then a full frame.
    ps2_edge(1'b0, 20, 1'b0, 1'b0);
    ps2_edge(1'b1, 20, 1'b0, 1'b0);
    ps2_edge(1'b0, 20, 1'b0, 1'b0);
    ps2_edge(1'b1, 20, 1'b0, 1'b0);
    ps2_edge(1'b1, 20, 1'b0, 1'b0);
    ps2_edge(1'b0, 20, 1'b0, 1'b0);
    repeat (3000) @(negedge clock);
    chk("to_idle_ready", {31'd0, ready}, 32'd0);
    send_frame(8'h5A, 1'b0, 1'b0, 20, 1'b0);
    chk("to_err", {31'd0, frame_err}, 32'd0);
    pop_chk("to", 8'h5A);
    chk("to_empty", {31'd0, ready}, 32'd0);

    // Nine frames, no reads: overflow and first eight retained.
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 1'b0, 1'b0, 20, 1'b0);
    end
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    for (int i = 1; i <= 8; i++) begin
      pop_chk($sformatf("ovf_pop%0d", i), 8'(i));
    end
    chk("ovf_empty", {31'd0, ready}, 32'd0);
    pulse_clr();
    chk("ovf_clr", {31'd0, overflow}, 32'd0);

    // Full FIFO, pop coincides with the ninth push: accepted, no overflow.
    for (int i = 1; i <= 8; i++) begin
      send_frame(8'(i), 1'b0, 1'b0, 20, 1'b0);
    end
    chk("full_no_ovf", {31'd0, overflow}, 32'd0);
    send_frame(8'h09, 1'b0, 1'b0, 20, 1'b1);
    chk("pushpop_ovf", {31'd0, overflow}, 32'd0);
    for (int i = 2; i <= 9; i++) begin
      pop_chk($sformatf("pp_pop%0d", i), 8'(i));
    end
    chk("pp_empty", {31'd0, ready}, 32'd0);

    // Reset mid-frame empties the FIFO; next frame received normally.
    send_frame(8'h33, 1'b0, 1'b0, 20, 1'b0);
    chk("pre_rst_ready", {31'd0, ready}, 32'd1);
    ps2_edge(1'b0, 20, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      ps2_edge(i[0], 20, 1'b0, 1'b0);
    end
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("mid_rst_ready", {31'd0, ready}, 32'd0);
    chk("mid_rst_data", {24'd0, data}, 32'd0);
    repeat (5) @(negedge clock);
    send_frame(8'h2A, 1'b0, 1'b0, 20, 1'b0);
    chk("post_rst_err", {31'd0, frame_err}, 32'd0);
    pop_chk("post_rst", 8'h2A);
    chk("post_rst_empty", {31'd0, ready}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
